// File: rtl/conv_out_collector.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | conv_out_collector: buffers conv_top beats and replays one OG per job on  |
// | a valid/ready stream. Optional checksum: define CONV_OUT_CKSUM_EN.        |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module conv_out_collector #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  cfg_n_beats,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic              err_stray,
  output logic [DATA_W-1:0] stat_cksum
);

  localparam int              c_aw       = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0]   c_full_cnt = (c_aw+1)'(FIFO_DEPTH);
  localparam logic [c_aw:0]   c_one_cnt  = (c_aw+1)'(1);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_collect = 2'd1;
  localparam logic [1:0] c_st_drain   = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw:0]     r_count;
  logic [CNT_W-1:0]  r_n;
  logic [CNT_W-1:0]  r_in_cnt;
  logic              r_done;
  logic              r_err_overflow;
  logic              r_err_stray;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_in_collect;
  logic w_accept_start;
  logic w_zero_start;
  logic w_last_in;
  logic w_tlast;
  logic w_job_end;

  assign w_empty        = (r_count == '0);
  assign w_full         = (r_count == c_full_cnt);
  assign w_pop          = !w_empty && m_tready;
  assign w_in_collect   = (r_state == c_st_collect);
  // A beat arriving on a full FIFO still fits if the head leaves this cycle.
  assign w_push         = w_in_collect && in_valid && (!w_full || w_pop);
  assign w_accept_start = (r_state == c_st_idle) && start && (cfg_n_beats != '0);
  assign w_zero_start   = (r_state == c_st_idle) && start && (cfg_n_beats == '0);
  assign w_last_in      = w_in_collect && in_valid && ((r_in_cnt + CNT_W'(1)) == r_n);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:    if (w_accept_start) w_state_nxt = c_st_collect;
      c_st_collect: if (w_last_in) w_state_nxt = c_st_drain;
      c_st_drain:   if (w_empty || (w_pop && w_tlast)) w_state_nxt = c_st_idle;
      default:      w_state_nxt = c_st_idle;
    endcase
  end

  // Output logic; an empty FIFO in DRAIN means every remaining beat was dropped.
  always_comb begin
    busy      = (r_state != c_st_idle);
    w_tlast   = (r_state == c_st_drain) && (r_count == c_one_cnt);
    w_job_end = ((r_state == c_st_drain) && (w_empty || (w_pop && w_tlast))) || w_zero_start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n            <= '0;
      r_in_cnt       <= '0;
      r_done         <= 1'b0;
      r_err_overflow <= 1'b0;
      r_err_stray    <= 1'b0;
    end else begin
      r_done <= w_job_end;
      if (w_accept_start) begin
        r_n            <= cfg_n_beats;
        r_in_cnt       <= '0;
        r_err_overflow <= 1'b0;
        r_err_stray    <= 1'b0;
      end else begin
        if (w_in_collect && in_valid) r_in_cnt <= r_in_cnt + CNT_W'(1);
        if (w_in_collect && in_valid && w_full && !w_pop) r_err_overflow <= 1'b1;
        if (!w_in_collect && in_valid) r_err_stray <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_one_cnt;
        2'b01:   r_count <= r_count - c_one_cnt;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  assign m_tvalid     = !w_empty;
  assign m_tdata      = w_empty ? '0 : r_mem[r_rd_ptr];
  assign m_tlast      = w_tlast;
  assign done         = r_done;
  assign err_overflow = r_err_overflow;
  assign err_stray    = r_err_stray;

`ifdef CONV_OUT_CKSUM_EN
  logic [DATA_W-1:0] r_cksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_cksum <= '0;
    else if (w_accept_start) r_cksum <= '0;
    else if (w_push)         r_cksum <= r_cksum ^ in_data;
  end

  assign stat_cksum = r_cksum;
`else
  assign stat_cksum = '0;
`endif

endmodule
`default_nettype wire
